// File: rtl/float_to_fixed_axis.sv
// float_to_fixed_axis: IEEE-754 single precision to signed Q(OUT_W-FRAC_W).FRAC_W.
// Two register stages (classify/exponent, then shift/round/saturate) sit between
// an AXI-Stream slave and master. Both stages advance together on a single enable,
// so a stalled output freezes the whole pipe and a bubble never blocks the output.
module float_to_fixed_axis #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_axis_a_tvalid,
  output logic             s_axis_a_tready,
  input  logic [31:0]      s_axis_a_tdata,
  output logic             m_axis_result_tvalid,
  input  logic             m_axis_result_tready,
  output logic [OUT_W-1:0] m_axis_result_tdata,
  output logic [1:0]       m_axis_result_tuser
);

  // Shift applied to the 24-bit significand: exp - 127 + FRAC_W - 23.
  localparam logic signed [9:0] SH_OFF  = 10'(FRAC_W - 150);
  // Largest positive magnitude and the magnitude of the most negative result.
  localparam logic [63:0]       POS_MAX = (64'd1 << (OUT_W - 1)) - 64'd1;
  localparam logic [63:0]       NEG_MAG = 64'd1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0]  MAX_VAL = POS_MAX[OUT_W-1:0];
  localparam logic [OUT_W-1:0]  MIN_VAL = NEG_MAG[OUT_W-1:0];

  // Stage 1 registers and their next-state values
  logic                st1_valid_q;
  logic                st1_sign_q,  st1_sign_d;
  logic                st1_zero_q,  st1_zero_d;
  logic                st1_inf_q,   st1_inf_d;
  logic                st1_nan_q,   st1_nan_d;
  logic [23:0]         st1_sig_q,   st1_sig_d;
  logic signed [9:0]   st1_sh_q,    st1_sh_d;

  // Output stage registers and their next-state values
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_data_q,  out_data_d;
  logic [1:0]          out_user_q,  out_user_d;

  // Stage 2 working signals
  logic                ce_s;
  logic [7:0]          in_exp_s;
  logic [22:0]         in_man_s;
  logic signed [9:0]   nsh_s;
  logic [24:0]         rtmp_s;
  logic [63:0]         mag_s;
  logic                big_s;
  logic                ovf_s;
  logic [OUT_W-1:0]    mag_lo_s;
  logic [OUT_W-1:0]    signed_s;

  // The pipe moves whenever the output register is empty or being drained.
  assign ce_s            = ~out_valid_q | m_axis_result_tready;
  assign s_axis_a_tready = ce_s;

  assign m_axis_result_tvalid = out_valid_q;
  assign m_axis_result_tdata  = out_data_q;
  assign m_axis_result_tuser  = out_user_q;

  // Stage 1: unpack the input word, classify it and compute the signed shift.
  always_comb begin
    in_exp_s   = s_axis_a_tdata[30:23];
    in_man_s   = s_axis_a_tdata[22:0];
    st1_sign_d = s_axis_a_tdata[31];
    st1_zero_d = (in_exp_s == 8'd0);
    st1_inf_d  = (in_exp_s == 8'hFF) && (in_man_s == 23'd0);
    st1_nan_d  = (in_exp_s == 8'hFF) && (in_man_s != 23'd0);
    st1_sig_d  = {1'b1, in_man_s};
    st1_sh_d   = $signed({2'b00, in_exp_s}) + SH_OFF;
  end

  // Stage 2: align the significand, round half away from zero, then saturate.
  always_comb begin
    nsh_s  = -st1_sh_q;
    rtmp_s = 25'd0;
    mag_s  = 64'd0;
    big_s  = 1'b0;
    if (st1_sh_q >= 10'sd0) begin
      if (st1_sh_q >= 10'sd40) begin
        big_s = 1'b1;
      end else begin
        mag_s = {40'd0, st1_sig_q} << st1_sh_q[5:0];
      end
    end else begin
      if (nsh_s > 10'sd40) begin
        mag_s = 64'd0;
      end else begin
        // Keep one guard bit below the LSB; adding it rounds ties away from zero.
        rtmp_s = {st1_sig_q, 1'b0} >> nsh_s[5:0];
        mag_s  = {40'd0, rtmp_s[24:1]} + {63'd0, rtmp_s[0]};
      end
    end

    // A negative result may reach exactly 2^(OUT_W-1); a positive one may not.
    if (st1_sign_q) begin
      ovf_s = big_s | (mag_s > NEG_MAG);
    end else begin
      ovf_s = big_s | (mag_s > POS_MAX);
    end

    mag_lo_s = mag_s[OUT_W-1:0];
    if (st1_sign_q) begin
      signed_s = (~mag_lo_s) + {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      signed_s = mag_lo_s;
    end

    if (st1_nan_q) begin
      out_data_d = {OUT_W{1'b0}};
      out_user_d = 2'b10;
    end else if (st1_inf_q) begin
      out_data_d = st1_sign_q ? MIN_VAL : MAX_VAL;
      out_user_d = 2'b01;
    end else if (st1_zero_q) begin
      out_data_d = {OUT_W{1'b0}};
      out_user_d = 2'b00;
    end else if (ovf_s) begin
      out_data_d = st1_sign_q ? MIN_VAL : MAX_VAL;
      out_user_d = 2'b01;
    end else begin
      out_data_d = signed_s;
      out_user_d = 2'b00;
    end
  end

  // Pipeline registers: clear on reset, otherwise advance both stages together on ce.
  always_ff @(posedge aclk) begin
    if (areset) begin
      st1_valid_q <= 1'b0;
      st1_sign_q  <= 1'b0;
      st1_zero_q  <= 1'b0;
      st1_inf_q   <= 1'b0;
      st1_nan_q   <= 1'b0;
      st1_sig_q   <= 24'd0;
      st1_sh_q    <= 10'sd0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_user_q  <= 2'b00;
    end else if (ce_s) begin
      st1_valid_q <= s_axis_a_tvalid;
      st1_sign_q  <= st1_sign_d;
      st1_zero_q  <= st1_zero_d;
      st1_inf_q   <= st1_inf_d;
      st1_nan_q   <= st1_nan_d;
      st1_sig_q   <= st1_sig_d;
      st1_sh_q    <= st1_sh_d;
      out_valid_q <= st1_valid_q;
      out_data_q  <= out_data_d;
      out_user_q  <= out_user_d;
    end
  end

endmodule

// File: tb/tb_float_to_fixed_axis.sv
// Directed bench for float_to_fixed_axis (OUT_W=16, FRAC_W=8): a driver pushes
// words and their hand-computed results into a queue; a negedge monitor checks
// every accepted output against it, plus latency, stall behaviour and reset.
module tb_float_to_fixed_axis;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  u;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        aclk;
  logic        areset;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic [1:0]  m_tuser;

  int   checks;
  int   fails;
  int   cyc;
  bit   bp_mode;
  bit   rdy_force;
  exp_t exp_q[$];
  exp_t e_mon;
  bit   prev_stall;
  logic [15:0] prev_data;
  logic [1:0]  prev_user;

  // Downstream ready pattern for the backpressure phase (7 low cycles out of 16).
  logic [15:0] bp_pat;

  // Special-case vectors with hand-computed results.
  logic [31:0] vin  [0:13];
  logic [15:0] vexp [0:13];
  logic [1:0]  vusr [0:13];

  float_to_fixed_axis #(.OUT_W(16), .FRAC_W(8)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_a_tvalid      (s_tvalid),
    .s_axis_a_tready      (s_tready),
    .s_axis_a_tdata       (s_tdata),
    .m_axis_result_tvalid (m_tvalid),
    .m_axis_result_tready (m_tready),
    .m_axis_result_tdata  (m_tdata),
    .m_axis_result_tuser  (m_tuser)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Cycle counter used for latency measurement.
  always @(posedge aclk) cyc <= cyc + 1;

  // Drive downstream ready shortly after each rising edge.
  always @(posedge aclk) begin
    #1;
    m_tready = bp_mode ? bp_pat[cyc % 16] : rdy_force;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [15:0] ed, input logic [1:0] eu,
                           input bit lat);
    bit   done;
    exp_t e;
    done = 1'b0;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge aclk);
      if (s_tready) begin
        e.d   = ed;
        e.u   = eu;
        e.cyc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        done  = 1'b1;
      end else begin
        @(posedge aclk);
        #1;
      end
    end
    check_val("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic idle_in();
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = 32'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(negedge aclk);
    end
    check_val("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Output monitor: scoreboard compare, latency, stall stability, ready under stall.
  always @(negedge aclk) begin
    if (areset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", {31'd0, m_tvalid}, 32'd1);
        check_val("hold_data", {16'd0, m_tdata}, {16'd0, prev_data});
        check_val("hold_user", {30'd0, m_tuser}, {30'd0, prev_user});
      end
      if (m_tvalid && !m_tready) begin
        check_val("stall_tready", {31'd0, s_tready}, 32'd0);
      end
      if (m_tvalid && m_tready) begin
        check_val("out_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          check_val("out_data", {16'd0, m_tdata}, {16'd0, e_mon.d});
          check_val("out_user", {30'd0, m_tuser}, {30'd0, e_mon.u});
          if (e_mon.lat) begin
            check_val("latency", cyc - e_mon.cyc, 32'd2);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_user  = m_tuser;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    fails     = 0;
    cyc       = 0;
    bp_mode   = 1'b0;
    rdy_force = 1'b1;
    bp_pat    = 16'b1011_0010_1101_0011;
    areset    = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = 32'd0;

    vin[0]  = 32'h43480000; vexp[0]  = 16'h7FFF; vusr[0]  = 2'b01; // 200.0 saturates
    vin[1]  = 32'hC3000000; vexp[1]  = 16'h8000; vusr[1]  = 2'b00; // -128.0 exact min
    vin[2]  = 32'hFF800000; vexp[2]  = 16'h8000; vusr[2]  = 2'b01; // -inf
    vin[3]  = 32'h3B000000; vexp[3]  = 16'h0001; vusr[3]  = 2'b00; // half LSB rounds up
    vin[4]  = 32'hBB000000; vexp[4]  = 16'hFFFF; vusr[4]  = 2'b00; // -half LSB
    vin[5]  = 32'h3A800000; vexp[5]  = 16'h0000; vusr[5]  = 2'b00; // quarter LSB
    vin[6]  = 32'h00000001; vexp[6]  = 16'h0000; vusr[6]  = 2'b00; // denormal
    vin[7]  = 32'h80000000; vexp[7]  = 16'h0000; vusr[7]  = 2'b00; // -0
    vin[8]  = 32'h7FC00000; vexp[8]  = 16'h0000; vusr[8]  = 2'b10; // NaN
    vin[9]  = 32'h7F800000; vexp[9]  = 16'h7FFF; vusr[9]  = 2'b01; // +inf
    vin[10] = 32'hC3010000; vexp[10] = 16'h8000; vusr[10] = 2'b01; // -129.0 below min
    vin[11] = 32'h42FE0000; vexp[11] = 16'h7F00; vusr[11] = 2'b00; // 127.0
    vin[12] = 32'h7F000000; vexp[12] = 16'h7FFF; vusr[12] = 2'b01; // 2^127, huge shift
    vin[13] = 32'hBA800000; vexp[13] = 16'h0000; vusr[13] = 2'b00; // negative rounds to 0

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_val("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("rst_tdata", {16'd0, m_tdata}, 32'd0);
    check_val("rst_tuser", {30'd0, m_tuser}, 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Back-to-back basic conversions with latency check
    send_word(32'h3F800000, 16'h0100, 2'b00, 1'b1);
    send_word(32'hC0200000, 16'hFD80, 2'b00, 1'b1);
    idle_in();
    wait_drain();

    // Saturation, rounding and special encodings, streamed back-to-back
    for (int i = 0; i < 14; i++) begin
      send_word(vin[i], vexp[i], vusr[i], 1'b1);
    end
    idle_in();
    wait_drain();

    // Backpressure: eight words against a stuttering downstream ready
    bp_mode = 1'b1;
    send_word(32'h3F800000, 16'h0100, 2'b00, 1'b0);
    send_word(32'hC0200000, 16'hFD80, 2'b00, 1'b0);
    send_word(32'h42FE0000, 16'h7F00, 2'b00, 1'b0);
    send_word(32'h3FC00000, 16'h0180, 2'b00, 1'b0);
    send_word(32'hC3000000, 16'h8000, 2'b00, 1'b0);
    send_word(32'h7F800000, 16'h7FFF, 2'b01, 1'b0);
    send_word(32'h7FC00000, 16'h0000, 2'b10, 1'b0);
    send_word(32'hBB000000, 16'hFFFF, 2'b00, 1'b0);
    idle_in();
    wait_drain();
    bp_mode = 1'b0;

    // Reset with two words in flight behind a stalled output
    rdy_force = 1'b0;
    send_word(32'h3F800000, 16'h0100, 2'b00, 1'b0);
    send_word(32'hC0200000, 16'hFD80, 2'b00, 1'b0);
    idle_in();
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check_val("inflight_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("inflight_rst_tdata", {16'd0, m_tdata}, 32'd0);
    check_val("inflight_rst_tuser", {30'd0, m_tuser}, 32'd0);
    rdy_force = 1'b1;
    repeat (4) @(negedge aclk);
    check_val("no_stale_tvalid", {31'd0, m_tvalid}, 32'd0);
    send_word(32'h3FC00000, 16'h0180, 2'b00, 1'b1);
    idle_in();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
